cpu_seq_ctrl_v: RTL and testbench
=================================

# cpu_seq_ctrl_v

Multi-cycle sequencer for the RV32I core datapath: walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the enable and strobe signals for:
- IR and PC registers,
- operand/ALU stage,
- data-memory port,
- register-file write port.

It handles the R_TYPE, I_IMM, I_LOAD and S_TYPE opcodes. Any other opcode halts the core with a sticky error. Both memory handshakes are guarded by a timeout.

## Interface
- MEM_TIMEOUT, 15: maximum number of request cycles allowed without ack on imem/dmem; legal range 1..255.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  leaves IDLE/HALT; ignored in all other states
- op  in  7  opcode field of IR; valid from DECODE until the next ir_we
- imem_ack  in  1  instruction memory has data/accepts fetch
- dmem_ack  in  1  data memory completes load/store
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load IR (one-cycle pulse)
- ex_en  out  1  capture operands / ALU result (one-cycle pulse)
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; meaningful only with dmem_req
- wb_sel  out  1  register write source: 0 = ALU, 1 = load data
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC <= PC+4 (one-cycle pulse at retire)
- state  out  3  current state code
- illegal  out  1  sticky: illegal opcode halt
- timeout  out  1  sticky: memory timeout halt
- retired  out  32  count of retired instructions

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6. Codes 7 and above map to HALT.
- Opcodes decoded:
  - R_TYPE = 7'b0110011
  - I_IMM = 7'b0010011
  - I_LOAD = 7'b0000011
  - S_TYPE = 7'b0100011
- IDLE: all strobes 0. start → FETCH.
- FETCH: imem_req=1.
  - On imem_ack: ir_we=1 in the same cycle, then → DECODE.
- DECODE: op is registered into op_q.
  - op is one of the four supported opcodes → EXECUTE.
  - Otherwise → HALT and set illegal.
- EXECUTE: ex_en=1 for one cycle.
  - R_TYPE or I_IMM → WB.
  - I_LOAD or S_TYPE → MEM.
- MEM: dmem_req=1; dmem_we=1 only if op_q is S_TYPE.
  - Store + dmem_ack: pc_we=1, retired+1, → FETCH.
  - Load + dmem_ack: → WB.
- WB: rf_we=1, wb_sel=(op_q==I_LOAD), pc_we=1, retired+1, → FETCH.
- HALT: all strobes 0; illegal/timeout hold their value.
  - start → FETCH, clearing illegal and timeout. retired is kept.
- Timeout:
  - Wait counter (8-bit) is cleared on entry to FETCH or MEM.
  - On each FETCH/MEM cycle with no ack: if counter==MEM_TIMEOUT-1, → HALT and set timeout; otherwise the counter increments.
  - An ack arriving in the final allowed cycle is accepted (ack wins).
- retired wraps modulo 2^32.
- Strobes are decoded from state (and ack for ir_we/pc_we) and are never asserted outside the states listed above.

## Timing
- Reset values: state=IDLE; op_q=0; counter=0; retired=0; illegal=0; timeout=0; every strobe 0.
- Reset takes effect asynchronously mid-instruction. Any in-flight request drops immediately.
- Latency with zero-wait acks (ack in the first request cycle):
  - R_TYPE / I_IMM: 4 cycles, FETCH→DECODE→EXECUTE→WB.
  - S_TYPE: 4 cycles, FETCH→DECODE→EXECUTE→MEM.
  - I_LOAD: 5 cycles.
- Each wait cycle adds exactly one cycle.
- Request/ack protocol: imem_req and dmem_req stay high until ack or timeout. Ack is ignored when the matching request is low.
- Pulse counts per instruction: ir_we, ex_en and pc_we are each exactly one cycle per instruction. rf_we is one cycle for R_TYPE, I_IMM and I_LOAD only.
- start is sampled only in IDLE or HALT; a start pulse while running has no effect.

## Test plan
- Reset, then start; R_TYPE (op=0x33), acks immediate → state sequence 1,2,3,5,1; rf_we=1 with wb_sel=0 in WB; pc_we pulse; retired=1 after 4 cycles.
- I_LOAD (op=0x03), dmem_ack delayed 3 cycles → dmem_req high with dmem_we=0 for 4 cycles; WB has wb_sel=1, rf_we=1; total 8 cycles; retired+1.
- S_TYPE (op=0x23), immediate ack → dmem_we=1 in MEM; rf_we never asserted; pc_we in the MEM ack cycle; returns to FETCH.
- op=0x63 (B-type) at DECODE → HALT (6), illegal=1; no ex_en/rf_we/pc_we. start → FETCH and illegal=0, retired unchanged.
- MEM_TIMEOUT=4, imem_ack held 0 → imem_req high for exactly 4 cycles, then HALT with timeout=1. Repeat with ack in cycle 4 → accepted, DECODE, timeout=0.
- Assert rst in mid-MEM with dmem_req=1 → asynchronously state=0, all outputs 0, retired=0; start afterwards resumes with FETCH.

Source files
------------

// File: rtl/cpu_seq_ctrl_v.sv
// cpu_seq_ctrl_v: RV32I multi-cycle sequencer (clk/rst/start, op, imem/dmem acks in; fetch/exec/mem/wb strobes, state, sticky illegal/timeout, retired count out)
module cpu_seq_ctrl_v #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        ex_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        wb_sel,
  output logic        rf_we,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6} state_t;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_IMM  = 7'b0010011;
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [7:0] LAST   = 8'(MEM_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ret_q, ret_d;
  logic        ill_q, ill_d, to_q, to_d;
  logic        legal, is_st, is_ld, last;
  assign legal   = op == R_TYPE || op == I_IMM || op == I_LOAD || op == S_TYPE;
  assign is_st   = op_q == S_TYPE;
  assign is_ld   = op_q == I_LOAD;
  assign last    = cnt_q == LAST;
  assign state   = state_q;
  assign illegal = ill_q;
  assign timeout = to_q;
  assign retired = ret_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  // The wait counter is zeroed on every transition into FETCH or MEM, so each
  // request phase gets the full MEM_TIMEOUT budget; ack is tested before the limit.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    ill_d    = ill_q;
    to_d     = to_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    ex_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wb_sel   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (last) begin
          state_d = HALT;
          to_d    = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      end
      DECODE: begin
        op_d    = op;
        state_d = legal ? EXECUTE : HALT;
        ill_d   = !legal;
      end
      EXECUTE: begin
        ex_en   = 1'b1;
        state_d = (is_ld || is_st) ? MEM : WB;
        cnt_d   = '0;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) begin
          pc_we   = is_st;
          ret_d   = is_st ? ret_q + 32'd1 : ret_q;
          state_d = is_st ? FETCH : WB;
          cnt_d   = '0;
        end else if (last) begin
          state_d = HALT;
          to_d    = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      end
      WB: begin
        rf_we   = 1'b1;
        wb_sel  = is_ld;
        pc_we   = 1'b1;
        ret_d   = ret_q + 32'd1;
        state_d = FETCH;
        cnt_d   = '0;
      end
      default: if (start) begin
        state_d = FETCH;
        ill_d   = 1'b0;
        to_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_cpu_seq_ctrl_v.sv
// tb_cpu_seq_ctrl_v: directed self-checking bench for cpu_seq_ctrl_v with MEM_TIMEOUT=4
module tb_cpu_seq_ctrl_v;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [6:0]  op = 7'd0;
  logic        imem_req, ir_we, ex_en, dmem_req, dmem_we, wb_sel, rf_we, pc_we, illegal, timeout;
  logic [2:0]  state;
  logic [31:0] retired;
  int n_chk = 0, n_pass = 0;
  cpu_seq_ctrl_v #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .ex_en(ex_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .wb_sel(wb_sel), .rf_we(rf_we), .pc_we(pc_we), .state(state), .illegal(illegal),
    .timeout(timeout), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] strobes;
    return {imem_req, ir_we, ex_en, dmem_req, dmem_we, wb_sel, rf_we, pc_we};
  endfunction
  task automatic test_reset;
    #3;
    n_chk++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else n_pass++;
    n_chk++; if (strobes() !== 8'h00) $display("FAIL rst_strobes got %h exp 00", strobes()); else n_pass++;
    n_chk++; if ({illegal, timeout, retired} !== 34'd0) $display("FAIL rst_flags got ill=%b to=%b ret=%0d exp 0/0/0", illegal, timeout, retired); else n_pass++;
    tick;
    rst = 1'b0;
    #1;
  endtask
  task automatic test_r_type;
    start = 1'b1;
    tick;
    start = 1'b0; imem_ack = 1'b1; op = 7'h33;
    #1;
    n_chk++; if ({state, imem_req, ir_we} !== {3'd1, 2'b11}) $display("FAIL rt_fetch got st=%0d req=%b ir_we=%b exp 1/1/1", state, imem_req, ir_we); else n_pass++;
    tick;
    imem_ack = 1'b0;
    #1;
    n_chk++; if ({state, imem_req} !== {3'd2, 1'b0}) $display("FAIL rt_decode got st=%0d req=%b exp 2/0", state, imem_req); else n_pass++;
    tick;
    n_chk++; if ({state, ex_en} !== {3'd3, 1'b1}) $display("FAIL rt_exec got st=%0d ex_en=%b exp 3/1", state, ex_en); else n_pass++;
    tick;
    n_chk++; if ({state, rf_we, wb_sel, pc_we, ex_en} !== {3'd5, 4'b1010}) $display("FAIL rt_wb got st=%0d rf=%b sel=%b pc=%b ex=%b exp 5/1/0/1/0", state, rf_we, wb_sel, pc_we, ex_en); else n_pass++;
    n_chk++; if (retired !== 32'd0) $display("FAIL rt_ret_wb got %0d exp 0", retired); else n_pass++;
    tick;
    n_chk++; if ({state, pc_we} !== {3'd1, 1'b0} || retired !== 32'd1) $display("FAIL rt_retire got st=%0d pc=%b ret=%0d exp 1/0/1", state, pc_we, retired); else n_pass++;
  endtask
  task automatic test_load;
    imem_ack = 1'b1; op = 7'h03;
    tick;
    imem_ack = 1'b0;
    tick;
    n_chk++; if ({state, ex_en} !== {3'd3, 1'b1}) $display("FAIL ld_exec got st=%0d ex=%b exp 3/1", state, ex_en); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if ({state, dmem_req, dmem_we, pc_we} !== {3'd4, 3'b100}) $display("FAIL ld_wait%0d got st=%0d req=%b we=%b pc=%b exp 4/1/0/0", i, state, dmem_req, dmem_we, pc_we); else n_pass++;
    end
    tick;
    dmem_ack = 1'b1;
    #1;
    n_chk++; if ({state, dmem_req, dmem_we, pc_we, rf_we} !== {3'd4, 4'b1000}) $display("FAIL ld_ack got st=%0d req=%b we=%b pc=%b rf=%b exp 4/1/0/0/0", state, dmem_req, dmem_we, pc_we, rf_we); else n_pass++;
    tick;
    dmem_ack = 1'b0;
    #1;
    n_chk++; if ({state, rf_we, wb_sel, pc_we, dmem_req} !== {3'd5, 4'b1110}) $display("FAIL ld_wb got st=%0d rf=%b sel=%b pc=%b req=%b exp 5/1/1/1/0", state, rf_we, wb_sel, pc_we, dmem_req); else n_pass++;
    tick;
    n_chk++; if (state !== 3'd1 || retired !== 32'd2) $display("FAIL ld_retire got st=%0d ret=%0d exp 1/2", state, retired); else n_pass++;
  endtask
  task automatic test_store;
    imem_ack = 1'b1; op = 7'h23;
    tick;
    imem_ack = 1'b0;
    tick;
    start = 1'b1;
    #1;
    tick;
    start = 1'b0; dmem_ack = 1'b1;
    #1;
    n_chk++; if ({state, dmem_req, dmem_we, pc_we, rf_we} !== {3'd4, 4'b1110}) $display("FAIL st_mem got st=%0d req=%b we=%b pc=%b rf=%b exp 4/1/1/1/0", state, dmem_req, dmem_we, pc_we, rf_we); else n_pass++;
    tick;
    dmem_ack = 1'b0;
    #1;
    n_chk++; if ({state, rf_we, pc_we} !== {3'd1, 2'b00} || retired !== 32'd3) $display("FAIL st_retire got st=%0d rf=%b pc=%b ret=%0d exp 1/0/0/3", state, rf_we, pc_we, retired); else n_pass++;
  endtask
  task automatic test_illegal;
    imem_ack = 1'b1; op = 7'h63;
    tick;
    imem_ack = 1'b0;
    #1;
    n_chk++; if (state !== 3'd2 || illegal !== 1'b0) $display("FAIL il_decode got st=%0d ill=%b exp 2/0", state, illegal); else n_pass++;
    tick;
    n_chk++; if ({state, illegal} !== {3'd6, 1'b1} || strobes() !== 8'h00) $display("FAIL il_halt got st=%0d ill=%b strobes=%h exp 6/1/00", state, illegal, strobes()); else n_pass++;
    tick;
    n_chk++; if ({state, illegal} !== {3'd6, 1'b1}) $display("FAIL il_hold got st=%0d ill=%b exp 6/1", state, illegal); else n_pass++;
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    n_chk++; if ({state, illegal} !== {3'd1, 1'b0} || retired !== 32'd3) $display("FAIL il_restart got st=%0d ill=%b ret=%0d exp 1/0/3", state, illegal, retired); else n_pass++;
  endtask
  task automatic test_timeout;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({state, imem_req} !== {3'd1, 1'b1}) $display("FAIL to_req%0d got st=%0d req=%b exp 1/1", i, state, imem_req); else n_pass++;
      tick;
    end
    n_chk++; if ({state, timeout, imem_req} !== {3'd6, 2'b10}) $display("FAIL to_halt got st=%0d to=%b req=%b exp 6/1/0", state, timeout, imem_req); else n_pass++;
    imem_ack = 1'b1;
    tick;
    n_chk++; if (state !== 3'd6) $display("FAIL to_ack_ignored got st=%0d exp 6", state); else n_pass++;
    imem_ack = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    n_chk++; if ({state, timeout} !== {3'd1, 1'b0}) $display("FAIL to_restart got st=%0d to=%b exp 1/0", state, timeout); else n_pass++;
    tick;
    tick;
    tick;
    imem_ack = 1'b1; op = 7'h03;
    tick;
    imem_ack = 1'b0;
    #1;
    n_chk++; if ({state, timeout} !== {3'd2, 1'b0}) $display("FAIL to_last_ack got st=%0d to=%b exp 2/0", state, timeout); else n_pass++;
  endtask
  task automatic test_reset_mid;
    tick;
    tick;
    n_chk++; if ({state, dmem_req} !== {3'd4, 1'b1}) $display("FAIL rm_mem got st=%0d req=%b exp 4/1", state, dmem_req); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (state !== 3'd0 || strobes() !== 8'h00 || retired !== 32'd0) $display("FAIL rm_async got st=%0d strobes=%h ret=%0d exp 0/00/0", state, strobes(), retired); else n_pass++;
    tick;
    rst = 1'b0;
    tick;
    n_chk++; if (state !== 3'd0) $display("FAIL rm_idle got st=%0d exp 0", state); else n_pass++;
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    n_chk++; if ({state, imem_req} !== {3'd1, 1'b1}) $display("FAIL rm_resume got st=%0d req=%b exp 1/1", state, imem_req); else n_pass++;
  endtask
  initial begin
    test_reset;
    test_r_type;
    test_load;
    test_store;
    test_illegal;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
